// File: rtl/packet_sum_accumulator_if.sv
// Operand stream in, packet-result stream out, for packet_sum_accumulator.
// The slave modport is the accumulator's view and the master modport is the surrounding logic's view.
interface packet_sum_accumulator_if #(
   parameter int N     = 8,
   parameter int CNT_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [N-1:0]     in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [N-1:0]     sum;
   logic             overflow;
   logic [CNT_W-1:0] count;

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, sum, overflow, count
   );

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, sum, overflow, count
   );
endinterface

// File: rtl/packet_sum_accumulator.sv
// Accumulates operands of a packet through a recursive ripple full_adder and
// presents the packet sum, a sticky carry-overflow flag and a saturating beat count.
module full_adder #(
   parameter int N = 8
) (
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         C_in,
   output logic [N-1:0] S,
   output logic         C_out
);
   generate
      if (N == 1) begin : g_bit
         assign S     = A ^ B ^ C_in;
         assign C_out = (A[0] & B[0]) | (C_in & (A[0] ^ B[0]));
      end else begin : g_split
         localparam int H = N / 2;
         logic c_mid;

         full_adder #(.N(H)) u_lo (
            .A     (A[H-1:0]),
            .B     (B[H-1:0]),
            .C_in  (C_in),
            .S     (S[H-1:0]),
            .C_out (c_mid)
         );

         full_adder #(.N(N-H)) u_hi (
            .A     (A[N-1:H]),
            .B     (B[N-1:H]),
            .C_in  (c_mid),
            .S     (S[N-1:H]),
            .C_out (C_out)
         );
      end
   endgenerate
endmodule

module packet_sum_accumulator #(
   parameter int N     = 8,
   parameter int CNT_W = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clear,
   packet_sum_accumulator_if.slave     bus
);
   typedef enum logic {ACC, HOLD} state_t;

   state_t           state_q, state_d;
   logic [N-1:0]     acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [N-1:0]     add_s;
   logic             add_c;
   logic             beat;

   full_adder #(.N(N)) u_add (
      .A     (acc_q),
      .B     (bus.in_data),
      .C_in  (1'b0),
      .S     (add_s),
      .C_out (add_c)
   );

   assign beat = bus.in_valid && (state_q == ACC);

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      // clear beats both a concurrent beat and a concurrent output handshake
      if (clear) begin
         state_d = ACC;
         acc_d   = '0;
         ovf_d   = 1'b0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ACC: begin
               if (beat) begin
                  acc_d = add_s;
                  ovf_d = ovf_q | add_c;
                  cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
                  if (bus.in_last) state_d = HOLD;
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  state_d = ACC;
                  acc_d   = '0;
                  ovf_d   = 1'b0;
                  cnt_d   = '0;
               end
            end
            default: state_d = ACC;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ACC;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   // Handshake outputs come from state alone, so there is no combinational input-to-output path
   assign bus.in_ready  = (state_q == ACC);
   assign bus.out_valid = (state_q == HOLD);
   assign bus.sum       = acc_q;
   assign bus.overflow  = ovf_q;
   assign bus.count     = cnt_q;
endmodule

// File: tb/tb_packet_sum_accumulator.sv
// Directed bench for packet_sum_accumulator; observed word is
// {out_valid, in_ready, overflow, count[3:0], sum[7:0]}.
module tb_packet_sum_accumulator;
   logic clk = 1'b0;
   logic rst;
   logic clear;
   int   checks = 0;
   int   errors = 0;
   logic [14:0] obs;
   logic [14:0] exp_w;

   packet_sum_accumulator_if #(.N(8), .CNT_W(4)) bus ();

   packet_sum_accumulator #(.N(8), .CNT_W(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      obs = {bus.out_valid, bus.in_ready, bus.overflow, bus.count, bus.sum};
   endtask

   task automatic send_beat(input logic [7:0] d, input logic last);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      step();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'd5;
      bus.in_last  = 1'b0;
      step();
      step();
      exp_w = {1'b0, 1'b1, 1'b0, 4'd0, 8'd0};
      checks++;
      if (obs !== exp_w) begin
         errors++;
         $display("FAIL reset_state got %h expected %h", obs, exp_w);
      end
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      step();
      checks++;
      if (obs !== exp_w) begin
         errors++;
         $display("FAIL reset_idle got %h expected %h", obs, exp_w);
      end
   endtask

   task automatic test_basic();
      bus.out_ready = 1'b1;
      send_beat(8'd3, 1'b0);
      send_beat(8'd5, 1'b0);
      exp_w = {1'b0, 1'b1, 1'b0, 4'd2, 8'd8};
      checks++;
      if (obs !== exp_w) begin
         errors++;
         $display("FAIL basic_partial got %h expected %h", obs, exp_w);
      end
      send_beat(8'd7, 1'b1);
      exp_w = {1'b1, 1'b0, 1'b0, 4'd3, 8'd15};
      checks++;
      if (obs !== exp_w) begin
         errors++;
         $display("FAIL basic_result got %h expected %h", obs, exp_w);
      end
      step();
      exp_w = {1'b0, 1'b1, 1'b0, 4'd0, 8'd0};
      checks++;
      if (obs !== exp_w) begin
         errors++;
         $display("FAIL basic_release got %h expected %h", obs, exp_w);
      end
   endtask

   task automatic test_hold();
      bus.out_ready = 1'b0;
      send_beat(8'd200, 1'b0);
      send_beat(8'd100, 1'b1);
      exp_w = {1'b1, 1'b0, 1'b1, 4'd2, 8'd44};
      checks++;
      if (obs !== exp_w) begin
         errors++;
         $display("FAIL hold_result got %h expected %h", obs, exp_w);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = 8'd50;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (obs !== exp_w) begin
            errors++;
            $display("FAIL hold_stable cycle %0d got %h expected %h", i, obs, exp_w);
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      step();
      exp_w = {1'b0, 1'b1, 1'b0, 4'd0, 8'd0};
      checks++;
      if (obs !== exp_w) begin
         errors++;
         $display("FAIL hold_release got %h expected %h", obs, exp_w);
      end
   endtask

   task automatic test_saturate();
      bus.out_ready = 1'b1;
      for (int i = 1; i <= 17; i++) send_beat(8'd1, (i == 17));
      exp_w = {1'b1, 1'b0, 1'b0, 4'd15, 8'd17};
      checks++;
      if (obs !== exp_w) begin
         errors++;
         $display("FAIL saturate_result got %h expected %h", obs, exp_w);
      end
      step();
   endtask

   task automatic test_clear();
      bus.out_ready = 1'b1;
      send_beat(8'd9, 1'b0);
      send_beat(8'd9, 1'b0);
      clear = 1'b1;
      send_beat(8'd9, 1'b0);
      clear = 1'b0;
      exp_w = {1'b0, 1'b1, 1'b0, 4'd0, 8'd0};
      checks++;
      if (obs !== exp_w) begin
         errors++;
         $display("FAIL clear_midpacket got %h expected %h", obs, exp_w);
      end
      send_beat(8'd4, 1'b1);
      exp_w = {1'b1, 1'b0, 1'b0, 4'd1, 8'd4};
      checks++;
      if (obs !== exp_w) begin
         errors++;
         $display("FAIL clear_next_packet got %h expected %h", obs, exp_w);
      end
      step();
      bus.out_ready = 1'b0;
      send_beat(8'd6, 1'b1);
      clear         = 1'b1;
      bus.out_ready = 1'b1;
      step();
      clear = 1'b0;
      exp_w = {1'b0, 1'b1, 1'b0, 4'd0, 8'd0};
      checks++;
      if (obs !== exp_w) begin
         errors++;
         $display("FAIL clear_in_hold got %h expected %h", obs, exp_w);
      end
   endtask

   task automatic test_single_rst();
      bus.out_ready = 1'b0;
      send_beat(8'd255, 1'b1);
      exp_w = {1'b1, 1'b0, 1'b0, 4'd1, 8'd255};
      checks++;
      if (obs !== exp_w) begin
         errors++;
         $display("FAIL single_result got %h expected %h", obs, exp_w);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_w = {1'b0, 1'b1, 1'b0, 4'd0, 8'd0};
      checks++;
      if (obs !== exp_w) begin
         errors++;
         $display("FAIL rst_in_hold got %h expected %h", obs, exp_w);
      end
   endtask

   initial begin
      rst           = 1'b1;
      clear         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      test_reset();
      test_basic();
      test_hold();
      test_saturate();
      test_clear();
      test_single_rst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
